// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// sequencing counter width, perf counter width and the pipeline-register
// control word with its canonical values.
package pipeline_ctrl_pkg;

   localparam int REG_ADDR_W_DEF = 4;
   localparam int CNT_W          = 4;
   localparam int PERF_W         = 16;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_t;

   // One bit per pipeline-register control, MSB first.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_flush;
      logic exmem_write;
   } ctrl_t;

   // Normal flow: everything advances, nothing cleared.
   localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   // Data memory busy (or in reset): nothing moves.
   localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Load-use: hold PC and IF/ID, inject a bubble into ID/EX, let EX drain.
   localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   // Taken branch: fetch the target, squash IF/ID and ID/EX.
   localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
// Purely combinational (0 cycles); shared with the forwarding unit.
// Ports: ID source addresses/usage, EX load/write/destination -> luse.
module hazard_detect #(
   parameter int REG_ADDR_W = 4,
   parameter int R0_IS_ZERO = 1
) (
   input  logic [REG_ADDR_W-1:0] id_rega_addr,
   input  logic [REG_ADDR_W-1:0] id_regb_addr,
   input  logic                  id_uses_rega,
   input  logic                  id_uses_regb,
   input  logic                  ex_data_mem,
   input  logic                  ex_write_inst,
   input  logic [REG_ADDR_W-1:0] ex_regc_addr,
   output logic                  luse
);

   logic match_a;
   logic match_b;
   logic r0_mask;

   assign match_a = id_uses_rega & (id_rega_addr == ex_regc_addr);
   assign match_b = id_uses_regb & (id_regb_addr == ex_regc_addr);
   // A load into the hardwired zero register never produces a usable value.
   assign r0_mask = (R0_IS_ZERO != 0) && (ex_regc_addr == '0);
   assign luse    = ex_data_mem & ex_write_inst & (match_a | match_b) & ~r0_mask;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: drives enable/flush of PC,
// IF/ID, ID/EX, EX/MEM. Mealy outputs; state and bubble counter registered.
// Ports: ID/EX hazard inputs, branch_taken, mem_busy -> *_write/*_flush,
// optional perf counters stall_cnt/flush_cnt (macro HAZARD_PERF_CNT_EN).
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
   parameter int FLUSH_CYCLES      = 1,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int R0_IS_ZERO        = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] id_regA_adress,
   input  logic [REG_ADDR_W-1:0] id_regB_adress,
   input  logic                  id_uses_regA,
   input  logic                  id_uses_regB,
   input  logic                  ex_data_mem,
   input  logic                  ex_write_inst,
   input  logic [REG_ADDR_W-1:0] ex_regC_adress,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_write,
   output logic [PERF_W-1:0]     stall_cnt,
   output logic [PERF_W-1:0]     flush_cnt
);

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl;
   logic             run_rules;
   logic             luse;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W),
      .R0_IS_ZERO (R0_IS_ZERO)
   ) u_hazard_detect (
      .id_rega_addr  (id_regA_adress),
      .id_regb_addr  (id_regB_adress),
      .id_uses_rega  (id_uses_regA),
      .id_uses_regb  (id_uses_regB),
      .ex_data_mem   (ex_data_mem),
      .ex_write_inst (ex_write_inst),
      .ex_regc_addr  (ex_regC_adress),
      .luse          (luse)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl      = CTRL_RUN;
      run_rules = 1'b0;

      case (state_q)
         RUN: run_rules = 1'b1;
         // Leaving MEM_WAIT is a full RUN decision, so a branch or hazard
         // that waited in EX behind the memory is acted on at release.
         MEM_WAIT: begin
            if (mem_busy) ctrl = CTRL_FREEZE;
            else          run_rules = 1'b1;
         end
         // Multi-cycle sequences pause (state and cnt held) under mem_busy.
         LOAD_STALL: begin
            if (mem_busy) begin
               ctrl = CTRL_FREEZE;
            end else begin
               ctrl = CTRL_STALL;
               // Counter loaded with N-1 on entry; last bubble is at cnt==1.
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            if (mem_busy) begin
               ctrl = CTRL_FREEZE;
            end else begin
               ctrl = CTRL_FLUSH;
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase

      if (run_rules) begin
         state_d = RUN;
         if (mem_busy) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
         end else if (branch_taken) begin
            // Branch beats luse: the ID instruction is squashed anyway.
            ctrl = CTRL_FLUSH;
            if (FLUSH_CYCLES > 1) begin
               state_d = FLUSH;
               cnt_d   = FLUSH_LOAD;
            end
         end else if (luse) begin
            ctrl = CTRL_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
               state_d = LOAD_STALL;
               cnt_d   = STALL_LOAD;
            end
         end
      end
   end

   // Hold every pipeline register still while reset is asserted.
   assign pc_write    = reset_n & ctrl.pc_write;
   assign ifid_write  = reset_n & ctrl.ifid_write;
   assign ifid_flush  = reset_n & ctrl.ifid_flush;
   assign idex_write  = reset_n & ctrl.idex_write;
   assign idex_flush  = reset_n & ctrl.idex_flush;
   assign exmem_write = reset_n & ctrl.exmem_write;

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
